// File: rtl/mem_pkg.sv
// mem_pkg
// Shared constants for the memory-access controller slice.
//   - FSM state encoding (kept as plain 2-bit constants so that older
//     tooling and waveform decoders that expect fixed values still work).
//   - Default RAM address and data widths.
//   - A helper that checks whether the upper MAR bits are all zero.
package mem_pkg;

  localparam int MEM_ADDR_W = 9;
  localparam int MEM_DATA_W = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // True when every MAR bit at or above position aw is zero, meaning the
  // address fits inside the RAM without wrapping.
  function automatic logic addr_upper_zero(input logic [31:0] addr, input int unsigned aw);
    return ((addr >> aw) == 32'd0);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if
// Bundles the control-unit handshake and the RAM bus of the memory-access
// controller.
//   slave  modport : controller view (requests and RAM read data in;
//                    RAM address/data/enables, Mdatain and status out).
//   master modport : environment view (control unit + RAM), the reverse.
// Signals:
//   read, write          request strobes, held until mem_ready
//   MAR_data_out         address from MAR (32 bits)
//   MDR_data_out         write data from MDR (32 bits)
//   ram_rdata            RAM read data, valid one cycle after ram_re
//   ram_addr, ram_wdata  registered RAM address / write data
//   ram_re, ram_we       RAM enables
//   Mdatain              last read word towards the MDR mux
//   mem_ready, busy      handshake status
//   mem_err              one-cycle pulse on an illegal request
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              read;
  logic              write;
  logic [31:0]       MAR_data_out;
  logic [31:0]       MDR_data_out;
  logic [DATA_W-1:0] ram_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_re;
  logic              ram_we;
  logic [DATA_W-1:0] Mdatain;
  logic              mem_ready;
  logic              busy;
  logic              mem_err;

  modport slave (
    input  read, write, MAR_data_out, MDR_data_out, ram_rdata,
    output ram_addr, ram_wdata, ram_re, ram_we, Mdatain, mem_ready, busy, mem_err
  );

  modport master (
    output read, write, MAR_data_out, MDR_data_out, ram_rdata,
    input  ram_addr, ram_wdata, ram_re, ram_we, Mdatain, mem_ready, busy, mem_err
  );
endinterface

// File: rtl/mem_access_ctrl_wait_counter.sv
// wait_counter
// Loadable down-counter with a zero flag. Used to time RAM wait states and
// reusable for I/O strobe timing. Stops at zero rather than wrapping.
// Ports:
//   clk       clock, rising edge
//   reset     synchronous active-low reset (count -> 0)
//   load      load load_val (takes priority over dec)
//   load_val  value to load
//   dec       decrement by one when non-zero
//   zero      count is zero
module wait_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_r;

  // Counter register: load wins over decrement, saturates at zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != {W{1'b0}})) begin
      count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {W{1'b0}});

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Sequential memory-access controller between the MAR/MDR pair and a
// synchronous RAM. A single read or write request is latched in IDLE, the
// RAM enable is held for WAIT_STATES+1 cycles in ACCESS (read data captured
// into Mdatain on the final edge), and DONE raises mem_ready until the
// originating request drops (4-phase handshake).
// Ports:
//   clk    clock, rising edge
//   reset  synchronous active-low reset
//   bus    mem_access_ctrl_if.slave (requests, RAM bus, Mdatain, status)
// Parameters: ADDR_W (RAM word address), DATA_W, WAIT_STATES (0..15).
// Build option: define MEM_RANGE_CHECK_EN to reject addresses whose bits
// above ADDR_W are non-zero (mem_err pulse, no RAM access, handshake still
// completes). Without it the upper address bits are truncated.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int DATA_W      = MEM_DATA_W,
  parameter int WAIT_STATES = 1
) (
  input logic              clk,
  input logic              reset,
  mem_access_ctrl_if.slave bus
);

  logic [1:0]        state_r;
  logic              is_read_r;    // originating request was a read
  logic              err_hold_r;   // blocks acceptance until both strobes drop
  logic [ADDR_W-1:0] ram_addr_r;
  logic [DATA_W-1:0] ram_wdata_r;
  logic              ram_re_r;
  logic              ram_we_r;
  logic [DATA_W-1:0] mdatain_r;
  logic              mem_ready_r;
  logic              busy_r;
  logic              mem_err_r;

  logic req_single_s;
  logic req_both_s;
  logic addr_bad_s;
  logic cnt_load_s;
  logic cnt_dec_s;
  logic cnt_zero_s;
  logic orig_req_s;

  // Request decode and wait-counter control.
  always_comb begin
    req_single_s = bus.read ^ bus.write;
    req_both_s   = bus.read & bus.write;
`ifdef MEM_RANGE_CHECK_EN
    addr_bad_s   = !addr_upper_zero(bus.MAR_data_out, ADDR_W);
`else
    addr_bad_s   = 1'b0;
`endif
    cnt_load_s   = (state_r == ST_IDLE) && !err_hold_r && req_single_s && !addr_bad_s;
    cnt_dec_s    = (state_r == ST_ACCESS);
    orig_req_s   = is_read_r ? bus.read : bus.write;
  end

  wait_counter #(.W(4)) u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load_s),
    .load_val (4'(WAIT_STATES)),
    .dec      (cnt_dec_s),
    .zero     (cnt_zero_s)
  );

  // Main FSM; every output is a register so the RAM and MDR see clean edges.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      is_read_r   <= 1'b0;
      err_hold_r  <= 1'b0;
      ram_addr_r  <= {ADDR_W{1'b0}};
      ram_wdata_r <= {DATA_W{1'b0}};
      ram_re_r    <= 1'b0;
      ram_we_r    <= 1'b0;
      mdatain_r   <= {DATA_W{1'b0}};
      mem_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      mem_err_r   <= 1'b0;
    end else begin
      mem_err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (err_hold_r) begin
            // After a read+write collision nothing is accepted until both drop.
            err_hold_r <= bus.read | bus.write;
          end else if (req_both_s) begin
            mem_err_r  <= 1'b1;
            err_hold_r <= 1'b1;
          end else if (req_single_s) begin
            is_read_r <= bus.read;
            busy_r    <= 1'b1;
            if (addr_bad_s) begin
              // Out-of-range: skip the RAM but finish the handshake.
              mem_err_r   <= 1'b1;
              mem_ready_r <= 1'b1;
              state_r     <= ST_DONE;
            end else begin
              ram_addr_r  <= bus.MAR_data_out[ADDR_W-1:0];
              ram_wdata_r <= bus.MDR_data_out;
              ram_re_r    <= bus.read;
              ram_we_r    <= bus.write;
              state_r     <= ST_ACCESS;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_ACCESS: begin
          if (cnt_zero_s) begin
            if (ram_re_r) begin
              mdatain_r <= bus.ram_rdata;
            end else begin
              mdatain_r <= mdatain_r;
            end
            ram_re_r    <= 1'b0;
            ram_we_r    <= 1'b0;
            mem_ready_r <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            state_r <= ST_ACCESS;
          end
        end

        ST_DONE: begin
          if (!orig_req_s) begin
            mem_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r <= ST_DONE;
          end
        end

        default: begin
          ram_re_r    <= 1'b0;
          ram_we_r    <= 1'b0;
          mem_ready_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ram_addr  = ram_addr_r;
  assign bus.ram_wdata = ram_wdata_r;
  assign bus.ram_re    = ram_re_r;
  assign bus.ram_we    = ram_we_r;
  assign bus.Mdatain   = mdatain_r;
  assign bus.mem_ready = mem_ready_r;
  assign bus.busy      = busy_r;
  assign bus.mem_err   = mem_err_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed table of transactions,
// hand-written reset / collision sequences and randomized transactions,
// all checked against a word-array memory model kept in the bench.
module tb_mem_access_ctrl;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int WS = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ram_clear = 1'b1;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: what the RAM should hold and what Mdatain should show.
  logic [31:0] ref_mem [512];
  logic [31:0] exp_md;

  // Environment RAM, synchronous, one cycle read latency.
  logic [31:0] ram [512];

  mem_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 512; i++) ram[i] <= 32'd0;
    end else begin
      if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
      if (bus.ram_re) bus.ram_rdata <= ram[bus.ram_addr];
    end
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_md;
    string       name;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete handshake; expectations come from the reference model.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit early_drop, input string tag);
    int n, re_c, we_c, err_c, addr_bad_c, exp_lat, exp_re, exp_we, exp_err;
    bit seen, bad;
    logic [8:0] idx;
    idx = addr[8:0];
`ifdef MEM_RANGE_CHECK_EN
    bad = (addr[31:9] != 23'd0);
`else
    bad = 1'b0;
`endif
    exp_lat = bad ? 1 : WS + 2;          // edges counted from the sampling edge
    exp_re  = (rd && !bad) ? WS + 1 : 0;
    exp_we  = (wr && !bad) ? WS + 1 : 0;
    exp_err = bad ? 1 : 0;
    if (!bad && wr) ref_mem[idx] = wdata;
    if (!bad && rd) exp_md = ref_mem[idx];

    bus.read = rd; bus.write = wr;
    bus.MAR_data_out = addr; bus.MDR_data_out = wdata;
    n = 0; re_c = 0; we_c = 0; err_c = 0; addr_bad_c = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      if (bus.ram_re) re_c++;
      if (bus.ram_we) we_c++;
      if (bus.mem_err) err_c++;
      if ((bus.ram_re || bus.ram_we) && (bus.ram_addr != idx)) addr_bad_c++;
      if (bus.mem_ready) seen = 1'b1;
      if (early_drop && n == 1) begin bus.read = 1'b0; bus.write = 1'b0; end
    end
    check({tag, " ready"}, 32'(seen), 32'd1);
    check({tag, " latency"}, n, exp_lat);
    check({tag, " re_cycles"}, re_c, exp_re);
    check({tag, " we_cycles"}, we_c, exp_we);
    check({tag, " err_pulses"}, err_c, exp_err);
    check({tag, " addr_stable"}, addr_bad_c, 32'd0);
    check({tag, " mdatain"}, bus.Mdatain, exp_md);
    if (!early_drop) begin
      tick();
      check({tag, " ready_hold"}, {bus.mem_ready, bus.busy}, 32'd3);
      bus.read = 1'b0; bus.write = 1'b0;
    end
    tick();
    check({tag, " release"}, {bus.mem_ready, bus.busy, bus.ram_re, bus.ram_we}, 32'd0);
  endtask

  initial begin
    int n, rdy;
    logic [31:0] a;
    bit r;

    for (int i = 0; i < 512; i++) ref_mem[i] = 32'd0;
    exp_md = 32'd0;

    tbl[0] = '{1'b0, 1'b1, 32'h0000_0012, 32'hDEAD_BEEF, 32'h0000_0000, "wr12"};
    tbl[1] = '{1'b1, 1'b0, 32'h0000_0012, 32'h0000_0000, 32'hDEAD_BEEF, "rd12"};
    tbl[2] = '{1'b0, 1'b1, 32'h0000_01FF, 32'h0000_00A5, 32'hDEAD_BEEF, "wr1ff"};
    tbl[3] = '{1'b1, 1'b0, 32'h0000_01FF, 32'h0000_0000, 32'h0000_00A5, "rd1ff"};
    tbl[4] = '{1'b0, 1'b1, 32'h0000_0000, 32'h1234_5678, 32'h0000_00A5, "wr000"};
`ifdef MEM_RANGE_CHECK_EN
    tbl[5] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0000_0000, 32'h0000_00A5, "rd200"};
`else
    tbl[5] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0000_0000, 32'h1234_5678, "rd200"};
`endif

    // Reset held with read asserted: everything stays quiet.
    bus.read = 1'b1; bus.write = 1'b0;
    bus.MAR_data_out = 32'h0000_0012; bus.MDR_data_out = 32'd0;
    repeat (2) begin
      tick();
      check("rst_ctrl", {bus.ram_re, bus.ram_we, bus.mem_ready, bus.busy, bus.mem_err}, 32'd0);
      check("rst_data", bus.ram_addr | bus.ram_wdata[8:0], 32'd0);
      check("rst_mdatain", bus.Mdatain, 32'd0);
    end
    reset = 1'b1; ram_clear = 1'b0;
    tick();
    check("rst_release_start", {bus.busy, bus.ram_re}, 32'd3);
    n = 0; rdy = 0;
    while (rdy == 0 && n < 20) begin
      tick(); n++;
      if (bus.mem_ready) rdy = 1;
    end
    check("rst_release_ready", rdy, 32'd1);
    check("rst_release_md", bus.Mdatain, exp_md);
    bus.read = 1'b0;
    tick();
    check("rst_release_idle", {bus.mem_ready, bus.busy}, 32'd0);

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      run_txn(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, 1'b0, tbl[i].name);
      check({tbl[i].name, " md_table"}, bus.Mdatain, tbl[i].exp_md);
    end

    // Read and write together: one error pulse, no access, blocked until both drop.
    bus.read = 1'b1; bus.write = 1'b1; bus.MAR_data_out = 32'h0000_0034;
    tick();
    check("both_err", bus.mem_err, 32'd1);
    check("both_noacc", {bus.ram_re, bus.ram_we, bus.busy}, 32'd0);
    tick();
    check("both_single_pulse", bus.mem_err, 32'd0);
    bus.write = 1'b0;
    tick(); tick();
    check("both_still_blocked", {bus.mem_err, bus.busy, bus.ram_re}, 32'd0);
    bus.read = 1'b0;
    tick();
    check("both_idle", {bus.mem_err, bus.busy, bus.mem_ready}, 32'd0);

    // Reset during the first ACCESS cycle of a read of 0x55.
    bus.read = 1'b1; bus.MAR_data_out = 32'h0000_0055;
    tick();
    check("midrst_access", {bus.busy, bus.ram_re}, 32'd3);
    reset = 1'b0;
    tick();
    check("midrst_abort", {bus.busy, bus.ram_re, bus.mem_ready}, 32'd0);
    check("midrst_md", bus.Mdatain, 32'd0);
    exp_md = 32'd0;
    reset = 1'b1; bus.read = 1'b0;
    rdy = 0;
    repeat (4) begin
      tick();
      if (bus.mem_ready) rdy++;
    end
    check("midrst_no_ready", rdy, 32'd0);

    // Randomized transactions against the reference model.
    for (int k = 0; k < 24; k++) begin
      r = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) a = $urandom();
      else a = 32'h0000_0100 + 32'($urandom_range(0, 7));
      run_txn(r, ~r, a, $urandom(), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
